// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle signed divider.
//   state_t    : controller states (IDLE, RUN, FIX, ZERO)
//   DIV_W      : operand/result width
//   CNT_W      : iteration counter width
//   DIV_ZERO_Q : quotient reported for a zero divisor
//   abs_mag    : two's-complement magnitude as an unsigned value
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  // 0x80000000 maps to itself, which reads correctly as 2^31 unsigned.
  function automatic logic [DIV_W-1:0] abs_mag(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/addsub_33.sv
// 33-bit adder/subtractor used by the divider datapath.
//   a, b : 33-bit operands
//   sub  : 1 selects a - b (as a + ~b + 1), 0 selects a + b
//   sum  : 33-bit result, carry out discarded
module addsub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  assign sum = a + (b ^ {33{sub}}) + {32'b0, sub};

endmodule

// File: rtl/div_32.sv
// Multi-cycle 32-bit signed divider (non-restoring, one quotient bit per clock).
//   clock, clear          : rising-edge clock, asynchronous active-high reset
//   start                 : request, sampled only while IDLE
//   dividend, divisor     : signed operands, captured on the accepting edge
//   busy                  : division in progress
//   done                  : one-cycle pulse, results valid from this cycle
//   quotient, remainder   : signed results (LO / HI), held until next done
//   div_by_zero           : set with done for a zero divisor, held until next done
//   state_dbg             : current controller state (div_pkg::state_t encoding)
//
// Handshake: start is a level sampled on any rising edge where the state is
// IDLE; there is no ready, an operation simply is or is not accepted. done
// pulses for exactly one cycle and the state is IDLE during that cycle, so a
// held start launches the next operation on the edge that ends the done cycle.
module div_32
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;       // signed partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // |dividend| shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;       // |divisor|
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_n_q, sgn_n_d;
  logic             sgn_d_q, sgn_d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   as_a;
  logic             as_sub;
  logic [WIDTH:0]   as_sum;
  logic [WIDTH:0]   p_fix;

  // One adder serves both phases: the shifted step in RUN, and the
  // add-back of D in FIX (sub is forced low outside RUN).
  assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign as_a    = (state_q == RUN) ? p_shift : p_q;
  assign as_sub  = (state_q == RUN) && !p_q[WIDTH];

  addsub_33 u_addsub (
    .a   (as_a),
    .b   ({1'b0, d_q}),
    .sub (as_sub),
    .sum (as_sum)
  );

  assign p_fix = p_q[WIDTH] ? as_sum : p_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    sgn_n_d = sgn_n_q;
    sgn_d_d = sgn_d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = '0;
          q_d     = abs_mag(dividend);
          d_d     = abs_mag(divisor);
          cnt_d   = '1;
          sgn_n_d = dividend[WIDTH-1];
          sgn_d_d = divisor[WIDTH-1];
          if (divisor == '0) begin
            state_d = ZERO;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        p_d   = as_sum;
        q_d   = {q_q[WIDTH-2:0], ~as_sum[WIDTH]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        p_d     = p_fix;
        quo_d   = (sgn_n_q ^ sgn_d_q) ? (~q_q + 1'b1) : q_q;
        rem_d   = sgn_n_q ? (~p_fix[WIDTH-1:0] + 1'b1) : p_fix[WIDTH-1:0];
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ZERO: begin
        // The raw dividend is rebuilt from its magnitude and sign.
        quo_d   = DIV_ZERO_Q;
        rem_d   = sgn_n_q ? (~q_q + 1'b1) : q_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      sgn_n_q <= 1'b0;
      sgn_d_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      sgn_n_q <= sgn_n_d;
      sgn_d_q <= sgn_d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_div_32.sv
module tb_div_32;

  localparam int EW = 97;  // {dbz, quotient, remainder, done cycle}

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic prev_done = 1'b0;

  div_32 #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (done === 1'b1) begin
      chk("done_one_cycle", {63'b0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = exp_q.pop_front();
        chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e[96]});
        chk("quotient",    {32'b0, quotient},    {32'b0, e[95:64]});
        chk("remainder",   {32'b0, remainder},   {32'b0, e[63:32]});
        chk("done_cycle",  64'(cyc),             {32'b0, e[31:0]});
      end
    end
    prev_done = done;
  end

  // driver tasks
  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done within %0d cycles expected done", limit);
    end
  endtask

  // Start edge is the posedge after this negedge; done expected lat edges later.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz);
    int lat;
    lat = edbz ? 2 : 34;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back({edbz, eq, er, 32'(cyc + lat)});
    @(negedge clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    chk("busy_after_start", {63'b0, busy}, {63'b0, ~edbz});
    wait_done(40);
    if (edbz) chk("busy_zero_done", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy",      {63'b0, busy},        64'd0);
    chk("rst_done",      {63'b0, done},        64'd0);
    chk("rst_quotient",  {32'b0, quotient},    64'd0);
    chk("rst_remainder", {32'b0, remainder},   64'd0);
    chk("rst_dbz",       {63'b0, div_by_zero}, 64'd0);
    chk("rst_state",     {62'b0, state_dbg},   64'd0);
    clear = 1'b0;

    do_div(32'd100,          32'd7,          32'd14,         32'd2,          1'b0);
    do_div(-32'sd100,        32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
    do_div(32'd100,          -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0);
    do_div(-32'sd100,        -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0);
    do_div(32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    do_div(32'd7,            32'd100,        32'd0,          32'd7,          1'b0);
    do_div(32'h7FFF_FFFF,    32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0);
    do_div(32'hFFFF_FFFF,    32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0);
    do_div(32'd12345,        32'd0,          32'hFFFF_FFFF,  32'd12345,      1'b1);
    do_div(-32'sd12345,      32'd0,          32'hFFFF_FFFF,  32'hFFFF_CFC7,  1'b1);
    do_div(32'd0,            32'd5,          32'd0,          32'd0,          1'b0);

    // start while busy is ignored
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    exp_q.push_back({1'b0, 32'd14, 32'd2, 32'(cyc + 34)});
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(40);

    // clear mid-operation aborts with no done
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 clear = 1'b1;
    #1;
    chk("abort_busy",      {63'b0, busy},        64'd0);
    chk("abort_done",      {63'b0, done},        64'd0);
    chk("abort_quotient",  {32'b0, quotient},    64'd0);
    chk("abort_remainder", {32'b0, remainder},   64'd0);
    chk("abort_dbz",       {63'b0, div_by_zero}, 64'd0);
    chk("abort_state",     {62'b0, state_dbg},   64'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (40) @(negedge clock);

    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    repeat (3) @(negedge clock);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
